// File: rtl/arb_stream_deframer_if.sv
// arb_stream_deframer_if: word stream in, parsed block words and status out
interface arb_stream_deframer_if;
  logic [15:0] din;
  logic        kchar;
  logic [15:0] dout;
  logic        dvalid;
  logic [3:0]  chan;
  logic [10:0] len;
  logic        hdr_valid;
  logic        eof;
  logic        err;
  logic        trig;
  logic [31:0] blk_cnt;
  logic [15:0] err_cnt;
  modport master (output din, kchar, input dout, dvalid, chan, len, hdr_valid, eof, err, trig, blk_cnt, err_cnt);
  modport slave  (input din, kchar, output dout, dvalid, chan, len, hdr_valid, eof, err, trig, blk_cnt, err_cnt);
endinterface

// File: rtl/arb_stream_deframer.sv
// arb_stream_deframer: parses arbiter blocks into channel-tagged words; ARB_DEFRAMER_CSUM_EN adds a trailing checksum word
module arb_stream_deframer #(
  parameter logic [7:0]  IDLE_K = 8'hBC,
  parameter logic [7:0]  TRIG_K = 8'h1C,
  parameter logic [10:0] MAXLEN = 11'd2047
) (
  input logic clk,
  input logic reset,
  arb_stream_deframer_if.slave s
);
  typedef enum logic [1:0] {IDLE, DATA, CSUM, SKIP} state_t;
  state_t state, state_n;
  logic [10:0] rem, rem_n;
  logic seen_k, dv_n, hv_n, eof_n, err_n, trig_n;
  logic is_trig, hdr_ok, unused_idle_k;
`ifdef ARB_DEFRAMER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
  logic [15:0] sum, sum_n;
  always_ff @(posedge clk) sum <= reset ? 16'h0 : sum_n;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  assign unused_idle_k = ^IDLE_K;
  assign is_trig = s.kchar && s.din[7:0] == TRIG_K;
  assign hdr_ok = s.din[15] && ({1'b0, s.din[10:0]} <= {1'b0, MAXLEN});
  // seen_k gates header parsing so a block cut off by reset is not misread as headers
  always_comb begin
    state_n = state;
    rem_n = rem;
    dv_n = 1'b0;
    hv_n = 1'b0;
    eof_n = 1'b0;
    err_n = 1'b0;
    trig_n = 1'b0;
`ifdef ARB_DEFRAMER_CSUM_EN
    sum_n = sum;
`endif
    case (state)
      DATA:
        if (s.kchar) begin
          err_n = 1'b1;
          trig_n = is_trig;
          state_n = IDLE;
        end else begin
          dv_n = 1'b1;
          rem_n = rem - 11'd1;
`ifdef ARB_DEFRAMER_CSUM_EN
          sum_n = sum + s.din;
`endif
          if (rem == 11'd1) begin
            state_n = CSUM_EN ? CSUM : IDLE;
            eof_n = !CSUM_EN;
          end
        end
      CSUM: begin
        state_n = IDLE;
`ifdef ARB_DEFRAMER_CSUM_EN
        eof_n = !s.kchar && s.din == sum;
`endif
        err_n = !eof_n;
      end
      default:
        if (s.kchar) begin
          trig_n = is_trig;
          state_n = IDLE;
        end else if (state == IDLE && seen_k) begin
          if (hdr_ok) begin
            hv_n = 1'b1;
            rem_n = s.din[10:0];
`ifdef ARB_DEFRAMER_CSUM_EN
            sum_n = s.din;
`endif
            if (s.din[10:0] != 11'd0) state_n = DATA;
            else begin
              state_n = CSUM_EN ? CSUM : IDLE;
              eof_n = !CSUM_EN;
            end
          end else begin
            err_n = 1'b1;
            state_n = SKIP;
          end
        end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem <= 11'd0;
      seen_k <= 1'b0;
      s.dout <= 16'h0;
      s.dvalid <= 1'b0;
      s.chan <= 4'h0;
      s.len <= 11'd0;
      s.hdr_valid <= 1'b0;
      s.eof <= 1'b0;
      s.err <= 1'b0;
      s.trig <= 1'b0;
      s.blk_cnt <= 32'h0;
      s.err_cnt <= 16'h0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      seen_k <= seen_k | s.kchar;
      if (dv_n) s.dout <= s.din;
      if (hv_n) begin
        s.chan <= s.din[14:11];
        s.len <= s.din[10:0];
      end
      s.dvalid <= dv_n;
      s.hdr_valid <= hv_n;
      s.eof <= eof_n;
      s.err <= err_n;
      s.trig <= trig_n;
      s.blk_cnt <= s.blk_cnt + {31'h0, eof_n};
      s.err_cnt <= s.err_cnt + {15'h0, err_n && s.err_cnt != 16'hFFFF};
    end
  end
endmodule
